// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM states, round count, rcon constants, S-box.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned IDX_W      = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? RCON_POLY : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, 0 maps to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel combinational S-box lookups on one 32-bit word.
module sub_word (
  input  logic [aes_pkg::WORD_W-1:0] word_i,
  output logic [aes_pkg::WORD_W-1:0] word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_o[8*i +: 8] = aes_pkg::sbox(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/round_key_schedule.sv
// AES-128 key expansion, one round key per cycle, with a registered read port.
module round_key_schedule #(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start,
  input  logic [aes_pkg::KEY_W-1:0]  key_in,
  input  logic                       key_req,
  input  logic [aes_pkg::IDX_W-1:0]  round_idx,
  output logic [aes_pkg::KEY_W-1:0]  round_key_out,
  output logic                       key_valid_out,
  output logic                       keys_ready,
  output logic                       done_out
);

  localparam int unsigned KEY_W    = aes_pkg::KEY_W;
  localparam int unsigned WORD_W   = aes_pkg::WORD_W;
  localparam int unsigned IDX_W    = aes_pkg::IDX_W;
  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  aes_pkg::state_e   state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [KEY_W-1:0]  cur_q, cur_d;
  logic              keys_ready_q, keys_ready_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [KEY_W-1:0]  rkey_q, rkey_d;

  logic [KEY_W-1:0]  keys_q [NUM_KEYS];
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [KEY_W-1:0]  wr_data;

  logic [WORD_W-1:0] w0, w1, w2, w3, rot_w3, sub_w3, temp;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [KEY_W-1:0]  next_key;

  assign w0 = cur_q[127:96];
  assign w1 = cur_q[95:64];
  assign w2 = cur_q[63:32];
  assign w3 = cur_q[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sub_word u_sub_word (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  // Next round key derived from the most recently stored one
  assign temp     = sub_w3 ^ {rcon_q, 24'h0};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    cur_d        = cur_q;
    keys_ready_d = keys_ready_q;
    done_d       = 1'b0;
    valid_d      = 1'b0;
    rkey_d       = rkey_q;
    wr_en        = 1'b0;
    wr_idx       = cnt_q;
    wr_data      = next_key;

    // Reads see the array before any write at this edge, so a same-edge restart serves old keys
    if (key_req && keys_ready_q && (round_idx <= LAST_IDX)) begin
      valid_d = 1'b1;
      rkey_d  = keys_q[round_idx];
    end

    case (state_q)
      aes_pkg::ST_IDLE, aes_pkg::ST_READY: begin
        if (start) begin
          wr_en        = 1'b1;
          wr_idx       = '0;
          wr_data      = key_in;
          cur_d        = key_in;
          rcon_d       = aes_pkg::RCON_INIT;
          cnt_d        = IDX_W'(1);
          keys_ready_d = 1'b0;
          state_d      = aes_pkg::ST_EXPAND;
        end
      end
      aes_pkg::ST_EXPAND: begin
        wr_en  = 1'b1;
        cur_d  = next_key;
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? aes_pkg::RCON_POLY : 8'h00);
        cnt_d  = IDX_W'(cnt_q + IDX_W'(1));
        if (cnt_q == LAST_IDX) begin
          state_d      = aes_pkg::ST_READY;
          keys_ready_d = 1'b1;
          done_d       = 1'b1;
        end
      end
      default: state_d = aes_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= aes_pkg::ST_IDLE;
      cnt_q        <= '0;
      rcon_q       <= aes_pkg::RCON_INIT;
      cur_q        <= '0;
      keys_ready_q <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      rkey_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      cur_q        <= cur_d;
      keys_ready_q <= keys_ready_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      rkey_q       <= rkey_d;
    end
  end

  // Key storage is left uninitialised by reset; keys_ready gates every read
  always_ff @(posedge clk_in) begin
    if (wr_en) keys_q[wr_idx] <= wr_data;
  end

  assign round_key_out = rkey_q;
  assign key_valid_out = valid_q;
  assign keys_ready    = keys_ready_q;
  assign done_out      = done_q;

endmodule

// File: doc/round_key_schedule.md
ROUND_KEY_SCHEDULE -- requirements
Module: round_key_schedule

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of AES-128 rounds; 10 is the only supported value.
REQ-002 clk_in  input  1  the clock; one clock domain.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; key_in is valid and expansion SHALL begin.
REQ-005 key_in  input  128  cipher key; [127:120] is key byte 0 and [127:96] is word w0.
REQ-006 key_req  input  1  single-cycle read request for one round key.
REQ-007 round_idx  input  4  round key index, 0..NUM_ROUNDS, sampled with key_req.
REQ-008 round_key_out  output  128  requested round key, in the same byte order as key_in.
REQ-009 key_valid_out  output  1  one-cycle pulse; round_key_out holds the requested key.
REQ-010 keys_ready  output  1  high while all NUM_ROUNDS+1 keys are stored and valid.
REQ-011 done_out  output  1  one-cycle pulse when expansion completes.

Function
REQ-012 FSM states: IDLE, EXPAND, READY.
REQ-013 In IDLE or READY, start SHALL do all of the following at the same edge:
- store key_in as key 0;
- set rcon to 8'h01 and the round counter to 1;
- clear keys_ready;
- go to EXPAND.
REQ-014 Each EXPAND cycle SHALL derive key i from key i-1 (FIPS-197):
- temp = SubWord(RotWord(w3)) ^ {rcon,24'h0};
- w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2';
- store key i, increment i.
REQ-015 rcon SHALL update as xtime: shift left by 1, then XOR 8'h1b when the old bit 7 was 1 (sequence 01,02,04,...,80,1b,36).
REQ-016 The edge that stores key NUM_ROUNDS SHALL move the FSM to READY and set keys_ready=1 and done_out=1.
- Timing: start sampled at edge N; keys 1..10 stored at edges N+1..N+10.
- done_out is high only for the cycle after edge N+10.
REQ-017 start while in EXPAND SHALL be ignored; the expansion in progress continues unchanged.
REQ-018 A key_req with keys_ready=1 and round_idx<=NUM_ROUNDS SHALL produce, at the next edge, round_key_out=key[round_idx] and key_valid_out=1 (latency 1).
REQ-019 A key_req with keys_ready=0 or round_idx>NUM_ROUNDS SHALL leave key_valid_out=0 and round_key_out unchanged.
REQ-020 key_req and start at the same edge in READY: the read SHALL be served from the old keys, then the restart proceeds.
REQ-021 key_req SHALL be accepted on consecutive cycles and in any order; the decipher path reads keys 10 down to 0.
REQ-022 key_valid_out SHALL be low in every cycle without a served request.

Reset
REQ-023 rst_in SHALL force all of the following, including mid-expansion:
- state=IDLE;
- keys_ready=0, done_out=0, key_valid_out=0;
- round_key_out=128'h0.
REQ-024 Stored key contents need not be cleared by reset; keys_ready=0 makes them unreadable.

Structure
REQ-025 The shared package aes_pkg SHALL hold the state typedef, NUM_ROUNDS, and the rcon initial value and reduction constant 8'h1b.
REQ-026 Sub-module sub_word SHALL perform four parallel combinational S-box lookups on 32 bits; it is the only instantiated sub-module.
REQ-027 Key storage SHALL be a register array of NUM_ROUNDS+1 128-bit entries; no RAM macro.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c:
- key 1 = a0fafe1788542cb123a339392a6c7605;
- key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Key 000102030405060708090a0b0c0d0e0f; read idx 10..0 back-to-back:
- key 10 = 13111d7fe3944a17f307a78b4d2b30c5;
- key 0 = key_in;
- 11 consecutive key_valid_out pulses.
REQ-030 start at edge N:
- done_out high exactly in the cycle after edge N+10;
- keys_ready rises at N+10;
- key_req issued before N+10 gives no key_valid_out.
REQ-031 Second start at edge N+4 with a different key: ignored, and the key 10 read back matches the first key.
REQ-032 rst_in at edge N+5:
- keys_ready=0, state IDLE;
- a later key_req gives no key_valid_out;
- a fresh start re-expands correctly.
REQ-033 round_idx=11 or 15 in READY: no key_valid_out, and round_key_out keeps its previous value.
